outbox_fifo: RTL and testbench
==============================

// Module: outbox_fifo
// PURPOSE
//  Consumer end of the CPU OUTBOX handshake. The control unit pulses wO for one cycle
//  with the accumulator on i_data, and stalls in DECODE while outFull is high.
//  This block buffers those words in a FIFO and presents them to the external reader
//  (display, UART or bench) on a valid/ready interface.
//  It also keeps occupancy and sticky error flags for the debug/dump path.
// PARAMETERS
//  DATA_W  8   width of one outbox word (CPU register width)
//  DEPTH   16  FIFO entries; power of two, >= 2
//  AW      4   log2(DEPTH); pointers are AW+1 bits
// PORTS
//  clk       in   1         system clock, all logic on rising edge
//  i_rst_n   in   1         reset, asynchronous assert, active-low
//  wO        in   1         CPU write strobe (one-cycle pulse in OUTBOX state)
//  i_data    in   DATA_W    word to enqueue, sampled when wO=1
//  outFull   out  1         FIFO full; CPU must not write
//  o_data    out  DATA_W    head-of-queue word, valid when o_valid=1
//  o_valid   out  1         queue not empty
//  i_ready   in   1         reader accepts head; pop when o_valid & i_ready
//  i_clr     in   1         synchronous flush of contents and sticky flags
//  o_count   out  AW+1      current occupancy, 0..DEPTH
//  o_ovf     out  1         sticky: a write arrived while full
//  o_udf     out  1         sticky: i_ready arrived while empty (diagnostic only)
// BEHAVIOUR
//  Reset (i_rst_n=0, async): wr_ptr=rd_ptr=0, o_count=0, outFull=0, o_valid=0,
//   o_ovf=0, o_udf=0. o_data is don't-care; memory is not cleared.
//  Storage: register array mem[DEPTH]. wr_ptr and rd_ptr are AW+1 bits.
//   Index = ptr[AW-1:0]. Pointers wrap naturally modulo 2*DEPTH.
//  Flags:
//   - o_count = wr_ptr - rd_ptr (AW+1-bit subtract).
//   - outFull = (o_count == DEPTH).
//   - o_valid = (o_count != 0).
//   - All three are driven from registered pointers, so there are no comb paths from wO/i_ready.
//  Push: at an edge with wO=1 and outFull=0:
//   - mem[wr_ptr] <= i_data
//   - wr_ptr <= wr_ptr+1
//  Pop: at an edge with i_ready=1 and o_valid=1: rd_ptr <= rd_ptr+1.
//  Read path: o_data = mem[rd_ptr[AW-1:0]], combinational (first-word-fall-through).
//  Latency: a word pushed at edge N drives o_valid=1 and o_data in the cycle after edge N.
//  Simultaneous push+pop, 0<count<DEPTH: both happen; count is unchanged.
//  Simultaneous events at the boundaries:
//   - Full + wO + i_ready: the pop happens; the write is dropped and o_ovf is set.
//     outFull is judged on pre-edge state.
//   - Empty + wO + i_ready: the push happens; the pop is ignored and o_udf is set.
//     The new word is then visible next cycle.
//  Overflow: wO while full -> data discarded, pointers hold, o_ovf <= 1 until clear/reset.
//  Underflow: i_ready while empty -> no pointer change, o_udf <= 1. Normal readers hold
//   i_ready high continuously, so o_udf is informational.
//  i_clr (sync, highest priority after reset):
//   - pointers <= 0, o_ovf <= 0, o_udf <= 0
//   - any push or pop in the same cycle is ignored
//  Reset mid-operation: asserting i_rst_n=0 at any time returns to the reset values above
//   immediately. A CPU stalled on outFull sees outFull=0 at once.
//  Control: no separate FSM. State is fully {wr_ptr, rd_ptr, o_ovf, o_udf}, all updated
//   only on clk or async reset.
// TESTING
//  1 Reset, then wO pulses with data 0x05,0x0A,0x0F and i_ready=0
//    -> o_count=3, o_valid=1, o_data=0x05, outFull=0.
//  2 Fill 16 words 0x00..0x0F, then a 17th wO with 0x99
//    -> outFull=1, o_count=16, o_ovf=1. Draining yields 0x00..0x0F in order; 0x99 never appears.
//  3 With count=5, hold wO=1 and i_ready=1 for 40 cycles with incrementing data
//    -> o_count stays 5; output order matches input order across pointer wrap (>2*DEPTH pushes).
//  4 When empty, wO=1 (0x42) and i_ready=1 in the same cycle
//    -> next cycle o_valid=1, o_data=0x42, o_count=1, o_udf=1.
//  5 When full, wO=1 and i_ready=1 in the same cycle
//    -> next cycle o_count=15, outFull=0, o_ovf=1, and the written word is absent.
//  6 With count=7 and o_ovf=1, pulse i_clr -> o_count=0, o_valid=0, flags 0.
//    Then drop i_rst_n mid-burst -> all outputs at reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/outbox_fifo_if.sv
// Outbox handshake bundle: CPU write side (wO/i_data/outFull) plus the
// reader side (o_data/o_valid/i_ready) of the outbox FIFO.
interface outbox_fifo_if #(
  parameter int DATA_W = 8
);
  logic              wO;
  logic [DATA_W-1:0] i_data;
  logic              outFull;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;

  // FIFO side
  modport slave (
    input  wO, i_data, i_ready,
    output outFull, o_data, o_valid
  );

  // CPU / reader side
  modport master (
    output wO, i_data, i_ready,
    input  outFull, o_data, o_valid
  );
endinterface

// File: rtl/outbox_fifo.sv
// Outbox FIFO: buffers CPU OUTBOX words and presents them first-word-fall-through
// on a valid/ready interface, with occupancy and sticky overflow/underflow flags.
module outbox_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic          clk,
  input  logic          i_rst_n,
  outbox_fifo_if.slave  bus,
  input  logic          i_clr,
  output logic [AW:0]   o_count,
  output logic          o_ovf,
  output logic          o_udf
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // Flags come only from registered pointers; the extra pointer bit tells full from empty.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  assign push = bus.wO & ~full;
  assign pop  = bus.i_ready & ~empty;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_ovf  <= 1'b0;
      o_udf  <= 1'b0;
    end else if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_ovf  <= 1'b0;
      o_udf  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
      if (bus.wO && full)
        o_ovf <= 1'b1;
      if (bus.i_ready && empty)
        o_udf <= 1'b1;
    end
  end

  // Storage is data only: never reset, and a flush simply discards the write.
  always_ff @(posedge clk) begin
    if (push && !i_clr)
      mem[wr_ptr[AW-1:0]] <= bus.i_data;
  end

  assign bus.o_data  = mem[rd_ptr[AW-1:0]];
  assign bus.o_valid = ~empty;
  assign bus.outFull = full;
  assign o_count     = count;

endmodule

// File: tb/tb_outbox_fifo.sv
// Self-checking bench for outbox_fifo: table-driven vectors plus a scoreboard
// queue of expected words, with hand-written sequences for the boundary cases.
module tb_outbox_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic          clk;
  logic          i_rst_n;
  logic          i_clr;
  logic [AW:0]   o_count;
  logic          o_ovf;
  logic          o_udf;

  outbox_fifo_if #(.DATA_W(DATA_W)) bus ();

  outbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .bus     (bus),
    .i_clr   (i_clr),
    .o_count (o_count),
    .o_ovf   (o_ovf),
    .o_udf   (o_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] q[$];
  int m_count;
  bit m_ovf;
  bit m_udf;

  typedef struct {
    bit       wo;
    bit [7:0] d;
    bit       rdy;
    bit       clr;
    int       cnt;
    bit       full;
    bit       valid;
    bit       ovf;
    bit       udf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_count"}, int'(o_count), m_count);
    chk({tag, "_full"},  int'(bus.outFull), int'(m_count == DEPTH));
    chk({tag, "_valid"}, int'(bus.o_valid), int'(m_count != 0));
    chk({tag, "_ovf"},   int'(o_ovf), int'(m_ovf));
    chk({tag, "_udf"},   int'(o_udf), int'(m_udf));
  endtask

  // Drives one clock cycle; pops are scored against the queue head before the edge.
  task automatic cycle(input bit wo, input logic [7:0] d, input bit rdy, input bit clr);
    bit mfull;
    bit mempty;
    bus.wO     = wo;
    bus.i_data = d;
    bus.i_ready = rdy;
    i_clr      = clr;
    mfull  = (m_count == DEPTH);
    mempty = (m_count == 0);
    if (clr) begin
      q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      if (rdy && !mempty) begin
        chk("pop_data", int'(bus.o_data), int'(q[0]));
        void'(q.pop_front());
        m_count--;
      end
      if (rdy && mempty)
        m_udf = 1'b1;
      if (wo && !mfull) begin
        q.push_back(d);
        m_count++;
      end
      if (wo && mfull)
        m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.wO      = 1'b0;
    bus.i_ready = 1'b0;
    i_clr       = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (m_count > 0 && guard < 4*DEPTH) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      guard++;
    end
    chk({tag, "_drained_valid"}, int'(bus.o_valid), 0);
    chk({tag, "_drained_count"}, int'(o_count), 0);
  endtask

  initial begin
    bus.wO      = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    i_clr       = 1'b0;
    i_rst_n     = 1'b0;
    m_count     = 0;
    m_ovf       = 1'b0;
    m_udf       = 1'b0;

    //            wo  d      rdy clr cnt full valid ovf udf
    vecs[0]  = '{1, 8'h05, 0, 0, 1, 0, 1, 0, 0};
    vecs[1]  = '{1, 8'h0A, 0, 0, 2, 0, 1, 0, 0};
    vecs[2]  = '{1, 8'h0F, 0, 0, 3, 0, 1, 0, 0};
    vecs[3]  = '{0, 8'h00, 0, 0, 3, 0, 1, 0, 0};
    vecs[4]  = '{0, 8'h00, 1, 0, 2, 0, 1, 0, 0};
    vecs[5]  = '{0, 8'h00, 1, 0, 1, 0, 1, 0, 0};
    vecs[6]  = '{0, 8'h00, 1, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 8'h00, 1, 0, 0, 0, 0, 0, 1};
    vecs[8]  = '{1, 8'h33, 0, 1, 0, 0, 0, 0, 0};
    vecs[9]  = '{1, 8'h42, 1, 0, 1, 0, 1, 0, 1};
    vecs[10] = '{0, 8'h00, 1, 0, 0, 0, 0, 0, 1};
    vecs[11] = '{0, 8'h00, 0, 1, 0, 0, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", int'(o_count), 0);
    chk("reset_full",  int'(bus.outFull), 0);
    chk("reset_valid", int'(bus.o_valid), 0);
    chk("reset_ovf",   int'(o_ovf), 0);
    chk("reset_udf",   int'(o_udf), 0);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors: three pushes, head check, drain, underflow, clear, empty push+pop.
    for (int i = 0; i < 12; i++) begin
      if (i == 3)
        chk("t1_head", int'(bus.o_data), 8'h05);
      if (i == 10)
        chk("t4_head", int'(bus.o_data), 8'h42);
      cycle(vecs[i].wo, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("vec%0d_count", i), int'(o_count), vecs[i].cnt);
      chk($sformatf("vec%0d_full", i),  int'(bus.outFull), int'(vecs[i].full));
      chk($sformatf("vec%0d_valid", i), int'(bus.o_valid), int'(vecs[i].valid));
      chk($sformatf("vec%0d_ovf", i),   int'(o_ovf), int'(vecs[i].ovf));
      chk($sformatf("vec%0d_udf", i),   int'(o_udf), int'(vecs[i].udf));
    end

    // Fill to full, overflow with 0x99, drain in order.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t2_full", int'(bus.outFull), 1);
    chk("t2_count16", int'(o_count), 16);
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    chk("t2_ovf", int'(o_ovf), 1);
    chk("t2_count_hold", int'(o_count), 16);
    chk_model("t2");
    drain("t2");

    // Full + write + read: pop happens, write dropped.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("t5_count", int'(o_count), 15);
    chk("t5_full", int'(bus.outFull), 0);
    chk("t5_ovf", int'(o_ovf), 1);
    chk("t5_head", int'(bus.o_data), 8'h21);
    drain("t5");

    // Steady push+pop at count 5 across pointer wrap.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
      chk("t3_count", int'(o_count), 5);
    end
    chk_model("t3");
    drain("t3");

    // Count 7 with ovf set, then clear.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++)
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_pre_count", int'(o_count), 7);
    chk("t6_pre_ovf", int'(o_ovf), 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t6_clr_count", int'(o_count), 0);
    chk("t6_clr_valid", int'(bus.o_valid), 0);
    chk("t6_clr_ovf", int'(o_ovf), 0);
    chk("t6_clr_udf", int'(o_udf), 0);

    // Async reset mid-burst while stalled on full.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    chk("t6_stall_full", int'(bus.outFull), 1);
    bus.wO = 1'b1;
    bus.i_data = 8'h55;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t6_rst_count", int'(o_count), 0);
    chk("t6_rst_full",  int'(bus.outFull), 0);
    chk("t6_rst_valid", int'(bus.o_valid), 0);
    chk("t6_rst_ovf",   int'(o_ovf), 0);
    chk("t6_rst_udf",   int'(o_udf), 0);
    bus.wO = 1'b0;
    q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    @(posedge clk);
    #2;
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    chk_model("t6_after");
    drain("t6_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
